// File: rtl/jk_flip_flop_pkg.sv
// Shared JK command encoding, packed as {j,k}.
package jk_flip_flop_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

endpackage : jk_flip_flop_pkg

// File: rtl/jk_flip_flop_cell.sv
// Purpose: single JK storage bit with synchronous active-high reset.
// Latency: q updates one clk edge after j/k are sampled.
// Backpressure: none; a command is accepted on every edge.
module jk_flip_flop_cell
  import jk_flip_flop_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // Reset has priority over every command, including toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (jk_cmd_e'({j, k}))
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
      endcase
    end
  end

endmodule : jk_flip_flop_cell

// File: rtl/jk_flip_flop.sv
// Purpose: WIDTH independent JK flip-flops sharing one clock and sync reset.
// Latency: one clk edge from j/k to q; q_n follows q with no extra delay.
// Backpressure: none; every bit accepts a new command on every edge.
module jk_flip_flop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_flip_flop_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  assign q_n = ~q;

endmodule : jk_flip_flop

// File: tb/tb_jk_flip_flop.sv
// Directed plus short random stimulus against a 4-bit JK register, scoreboard checked.
module tb_jk_flip_flop;

  localparam int W = 4;
  localparam logic [W-1:0] ALL = '1;
  localparam logic [W-1:0] NONE = '0;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] q_n;

  exp_t         sb[$];
  logic [W-1:0] mq;
  int           checks;
  int           errors;

  jk_flip_flop #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (q),
    .q_n (q_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour written from the characteristic equation.
  function automatic logic [W-1:0] jk_model(input logic r, input logic [W-1:0] jj,
                                            input logic [W-1:0] kk, input logic [W-1:0] cur);
    if (r) return '0;
    return (jj & ~cur) | (~kk & cur);
  endfunction

  task automatic step(input string tag, input logic r, input logic [W-1:0] jj,
                      input logic [W-1:0] kk, input bit glitch);
    exp_t e;
    @(negedge clk);
    rst = r;
    j   = jj;
    k   = kk;
    mq  = jk_model(r, jj, kk, mq);
    e.tag = tag;
    e.q   = mq;
    sb.push_back(e);
    if (glitch) begin
      // Short j pulse that is gone well before the next rising edge.
      #2 j = ALL;
      #2 j = jj;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (q === e.q) else begin
      errors++;
      $error("FAIL %s q observed=%b expected=%b", e.tag, q, e.q);
    end
    checks++;
    assert (q_n === ~e.q) else begin
      errors++;
      $error("FAIL %s_qn q_n observed=%b expected=%b", e.tag, q_n, ~e.q);
    end
  endtask

  initial begin
    logic [W-1:0] rj;
    logic [W-1:0] rk;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    j   = '0;
    k   = '0;
    mq  = '0;

    // Reset, then holding keeps zero.
    step("rst0", 1'b1, NONE, NONE, 1'b0);
    step("hold0a", 1'b0, NONE, NONE, 1'b0);
    step("hold0b", 1'b0, NONE, NONE, 1'b0);

    // Set, reset, toggle, hold.
    step("rst1", 1'b1, NONE, NONE, 1'b0);
    step("set", 1'b0, ALL, NONE, 1'b0);
    step("clr", 1'b0, NONE, ALL, 1'b0);
    step("tgl", 1'b0, ALL, ALL, 1'b0);
    step("hold1", 1'b0, NONE, NONE, 1'b0);

    // Continuous toggle divides the clock by two.
    step("rst2", 1'b1, NONE, NONE, 1'b0);
    for (int n = 0; n < 6; n++) step($sformatf("div2_%0d", n), 1'b0, ALL, ALL, 1'b0);

    // Reset beats toggle on the same edge, then toggling resumes.
    step("set2", 1'b0, ALL, NONE, 1'b0);
    step("rst_vs_tgl", 1'b1, ALL, ALL, 1'b0);
    step("tgl_after_rst", 1'b0, ALL, ALL, 1'b0);

    // j glitch between edges must not be captured.
    step("rst3", 1'b1, NONE, NONE, 1'b0);
    step("glitch", 1'b0, NONE, NONE, 1'b1);

    // Per-bit independence: set, reset, toggle and hold in one word.
    step("rst4", 1'b1, NONE, NONE, 1'b0);
    step("mix0", 1'b0, 4'b1010, 4'b0110, 1'b0);
    step("mix1", 1'b0, 4'b1010, 4'b0110, 1'b0);

    // Random commands from a known state.
    for (int n = 0; n < 16; n++) begin
      rj = W'($urandom);
      rk = W'($urandom);
      step($sformatf("rnd_%0d", n), ($urandom_range(0, 7) == 0), rj, rk, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jk_flip_flop
